// File: rtl/custom_ip_axil_pkg.sv
// Shared types and constants for the custom_ip AXI4-Lite register slave.
package custom_ip_axil_pkg;

    localparam int unsigned NUM_REGS      = 4;
    localparam int unsigned REG_IDX_W     = 2;
    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } wr_state_e;

    function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/custom_ip_axil_regfile.sv
// Byte-strobed register array: one synchronous write port, one combinational read port.
module custom_ip_axil_regfile
    import custom_ip_axil_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en,
    input  logic [REG_IDX_W-1:0]               wr_idx,
    input  logic [DATA_W-1:0]                  wr_data,
    input  logic [DATA_W/8-1:0]                wr_strb,
    input  logic [REG_IDX_W-1:0]               rd_idx,
    output logic [DATA_W-1:0]                  rd_data,
    output logic [NUM_REGS-1:0][DATA_W-1:0]    regs
);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int unsigned b = 0; b < DATA_W/8; b++) begin
                if (wr_strb[b]) begin
                    mem_d[wr_idx][b*8 +: 8] = wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_idx];
    assign regs    = mem_q;

endmodule

// File: rtl/custom_ip_axil_slave.sv
// AXI4-Lite slave exposing four 32-bit registers to the fabric, with per-register write strobes.
module custom_ip_axil_slave
    import custom_ip_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                                         ACLK,
    input  logic                                         ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S00_AXI_AWADDR,
    input  logic [2:0]                                   S00_AXI_AWPROT,
    input  logic                                         S00_AXI_AWVALID,
    output logic                                         S00_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                S00_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]              S00_AXI_WSTRB,
    input  logic                                         S00_AXI_WVALID,
    output logic                                         S00_AXI_WREADY,
    output logic [1:0]                                   S00_AXI_BRESP,
    output logic                                         S00_AXI_BVALID,
    input  logic                                         S00_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S00_AXI_ARADDR,
    input  logic [2:0]                                   S00_AXI_ARPROT,
    input  logic                                         S00_AXI_ARVALID,
    output logic                                         S00_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                S00_AXI_RDATA,
    output logic [1:0]                                   S00_AXI_RRESP,
    output logic                                         S00_AXI_RVALID,
    input  logic                                         S00_AXI_RREADY,
    output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0]  reg_out,
    output logic [NUM_REGS-1:0]                          reg_wr_pulse
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;

    wr_state_e             state_q, state_d;
    logic                  aw_full_q, aw_full_d;
    logic [REG_IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic                  w_full_q, w_full_d;
    logic [DW-1:0]         w_data_q, w_data_d;
    logic [SW-1:0]         w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic                  rvalid_q, rvalid_d;
    logic                  arready_q, arready_d;
    logic [DW-1:0]         rdata_q, rdata_d;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  commit;
    logic [REG_IDX_W-1:0]  cm_idx;
    logic [DW-1:0]         cm_data;
    logic [SW-1:0]         cm_strb;
    logic [DW-1:0]         rf_rd_data;
    logic                  unused_ok;

    assign unused_ok = ^{S00_AXI_AWPROT, S00_AXI_ARPROT,
                         S00_AXI_AWADDR[1:0], S00_AXI_ARADDR[1:0]};

    assign aw_hs = S00_AXI_AWVALID && awready_q;
    assign w_hs  = S00_AXI_WVALID  && wready_q;
    assign ar_hs = S00_AXI_ARVALID && arready_q;

    // Commit operands come from the holding registers when buffered, else straight from the bus.
    assign cm_idx  = aw_full_q ? aw_idx_q : S00_AXI_AWADDR[3:2];
    assign cm_data = w_full_q  ? w_data_q : S00_AXI_WDATA;
    assign cm_strb = w_full_q  ? w_strb_q : S00_AXI_WSTRB;

    always_comb begin
        state_d   = state_q;
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        commit    = 1'b0;

        case (state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                end else if (aw_hs) begin
                    aw_full_d = 1'b1;
                    aw_idx_d  = S00_AXI_AWADDR[3:2];
                    state_d   = W_HAVE_A;
                end else if (w_hs) begin
                    w_full_d = 1'b1;
                    w_data_d = S00_AXI_WDATA;
                    w_strb_d = S00_AXI_WSTRB;
                    state_d  = W_HAVE_D;
                end
            end
            W_HAVE_A: if (w_hs)  commit = 1'b1;
            W_HAVE_D: if (aw_hs) commit = 1'b1;
            W_RESP: begin
                if (bvalid_q && S00_AXI_BREADY) begin
                    bvalid_d = 1'b0;
                    state_d  = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase

        if (commit) begin
            state_d   = W_RESP;
            bvalid_d  = 1'b1;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end

        awready_d  = !aw_full_d && !bvalid_d;
        wready_d   = !w_full_d  && !bvalid_d;
        wr_pulse_d = commit ? idx_onehot(cm_idx) : '0;

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rvalid_q && S00_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        // Read port sees pre-edge contents, so a same-cycle commit returns the old value.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rf_rd_data;
        end
        arready_d = !rvalid_d;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= W_IDLE;
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            wr_pulse_q <= '0;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            wr_pulse_q <= wr_pulse_d;
            rvalid_q   <= rvalid_d;
            arready_q  <= arready_d;
            rdata_q    <= rdata_d;
        end
    end

    custom_ip_axil_regfile #(
        .DATA_W (DW)
    ) u_regfile (
        .clk     (ACLK),
        .rst     (ARESET),
        .wr_en   (commit),
        .wr_idx  (cm_idx),
        .wr_data (cm_data),
        .wr_strb (cm_strb),
        .rd_idx  (S00_AXI_ARADDR[3:2]),
        .rd_data (rf_rd_data),
        .regs    (reg_out)
    );

    assign S00_AXI_AWREADY = awready_q;
    assign S00_AXI_WREADY  = wready_q;
    assign S00_AXI_BVALID  = bvalid_q;
    assign S00_AXI_BRESP   = AXI_RESP_OKAY;
    assign S00_AXI_ARREADY = arready_q;
    assign S00_AXI_RVALID  = rvalid_q;
    assign S00_AXI_RDATA   = rdata_q;
    assign S00_AXI_RRESP   = AXI_RESP_OKAY;
    assign reg_wr_pulse    = wr_pulse_q;

endmodule

// File: tb/tb_custom_ip_axil_slave.sv
// Directed bench for custom_ip_axil_slave: vector table plus hand-written multi-cycle sequences.
module tb_custom_ip_axil_slave;

    logic             clk;
    logic             rst;
    logic [3:0]       awaddr;
    logic [2:0]       awprot;
    logic             awvalid;
    logic             awready;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic             wvalid;
    logic             wready;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready;
    logic [3:0]       araddr;
    logic [2:0]       arprot;
    logic             arvalid;
    logic             arready;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic             rvalid;
    logic             rready;
    logic [3:0][31:0] reg_out;
    logic [3:0]       reg_wr_pulse;

    int checks   = 0;
    int failures = 0;

    custom_ip_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) dut (
        .ACLK            (clk),
        .ARESET          (rst),
        .S00_AXI_AWADDR  (awaddr),
        .S00_AXI_AWPROT  (awprot),
        .S00_AXI_AWVALID (awvalid),
        .S00_AXI_AWREADY (awready),
        .S00_AXI_WDATA   (wdata),
        .S00_AXI_WSTRB   (wstrb),
        .S00_AXI_WVALID  (wvalid),
        .S00_AXI_WREADY  (wready),
        .S00_AXI_BRESP   (bresp),
        .S00_AXI_BVALID  (bvalid),
        .S00_AXI_BREADY  (bready),
        .S00_AXI_ARADDR  (araddr),
        .S00_AXI_ARPROT  (arprot),
        .S00_AXI_ARVALID (arvalid),
        .S00_AXI_ARREADY (arready),
        .S00_AXI_RDATA   (rdata),
        .S00_AXI_RRESP   (rresp),
        .S00_AXI_RVALID  (rvalid),
        .S00_AXI_RREADY  (rready),
        .reg_out         (reg_out),
        .reg_wr_pulse    (reg_wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Presents AW and W together, waits for B; checks the write strobe in the BVALID cycle.
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_ok, w_ok, awr, wr;
        int n;
        logic [3:0] exp_pulse;
        aw_ok = 0; w_ok = 0; n = 0;
        exp_pulse = 4'b0001 << a[3:2];
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_ok && w_ok) && n < 50) begin
            awr = awready; wr = wready;
            @(posedge clk);
            if (awr && awvalid) aw_ok = 1;
            if (wr && wvalid)   w_ok  = 1;
            #1;
            if (aw_ok) awvalid = 1'b0;
            if (w_ok)  wvalid  = 1'b0;
            @(negedge clk);
            n++;
        end
        check("wr_accept", {31'd0, aw_ok && w_ok}, 32'd1);
        n = 0;
        while (!bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wr_bvalid", {31'd0, bvalid}, 32'd1);
        check("wr_bresp", {30'd0, bresp}, 32'd0);
        check("wr_pulse", {28'd0, reg_wr_pulse}, {28'd0, exp_pulse});
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
        bit done;
        int n;
        done = 0; n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        while (!done && n < 50) begin
            done = arready;
            @(posedge clk);
            #1;
            if (done) arvalid = 1'b0;
            @(negedge clk);
            n++;
        end
        check("rd_accept", {31'd0, done}, 32'd1);
        n = 0;
        while (!rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rd_rvalid", {31'd0, rvalid}, 32'd1);
        d = rdata;
        r = rresp;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          is_wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [13];
    logic [31:0] rd;
    logic [1:0]  rr;

    initial begin
        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;

        vecs[0]  = '{1'b1, 4'h0, 32'h0000_0001, 4'hF, 32'h0};
        vecs[1]  = '{1'b1, 4'h4, 32'h0000_0002, 4'hF, 32'h0};
        vecs[2]  = '{1'b1, 4'h8, 32'h0000_0003, 4'hF, 32'h0};
        vecs[3]  = '{1'b1, 4'hC, 32'h0000_0004, 4'hF, 32'h0};
        vecs[4]  = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0000_0001};
        vecs[5]  = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_0002};
        vecs[6]  = '{1'b0, 4'h8, 32'h0,         4'h0, 32'h0000_0003};
        vecs[7]  = '{1'b0, 4'hC, 32'h0,         4'h0, 32'h0000_0004};
        vecs[8]  = '{1'b1, 4'h8, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vecs[9]  = '{1'b1, 4'h8, 32'h1234_5678, 4'h5, 32'h0};
        vecs[10] = '{1'b0, 4'hA, 32'h0,         4'h0, 32'hFF34_FF78};
        vecs[11] = '{1'b1, 4'hE, 32'hAAAA_AAAA, 4'h0, 32'h0};
        vecs[12] = '{1'b0, 4'hF, 32'h0,         4'h0, 32'h0000_0004};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_pulse", {28'd0, reg_wr_pulse}, 32'd0);
        for (int i = 0; i < 4; i++) check("rst_reg", reg_out[i], 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_awready", {31'd0, awready}, 32'd1);
        check("post_rst_wready", {31'd0, wready}, 32'd1);
        check("post_rst_arready", {31'd0, arready}, 32'd1);

        // Vector table: writes, readbacks, strobes, ignored low address bits
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            end else begin
                axi_read(vecs[i].addr, rd, rr);
                check("vec_rdata", rd, vecs[i].exp);
                check("vec_rresp", {30'd0, rr}, 32'd0);
                check("vec_reg_out", reg_out[vecs[i].addr[3:2]], vecs[i].exp);
            end
        end

        // W three cycles ahead of AW
        @(negedge clk);
        check("wfirst_wready", {31'd0, wready}, 32'd1);
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk);
        #1 wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wfirst_no_bvalid", {31'd0, bvalid}, 32'd0);
            check("wfirst_wready_low", {31'd0, wready}, 32'd0);
        end
        check("wfirst_awready", {31'd0, awready}, 32'd1);
        awaddr = 4'h4; awvalid = 1'b1;
        @(posedge clk);
        #1 awvalid = 1'b0;
        check("wfirst_bvalid", {31'd0, bvalid}, 32'd1);
        check("wfirst_reg1", reg_out[1], 32'hDEAD_BEEF);
        check("wfirst_pulse", {28'd0, reg_wr_pulse}, 32'h2);
        @(posedge clk);
        #1;
        check("wfirst_bvalid_clr", {31'd0, bvalid}, 32'd0);
        check("wfirst_pulse_clr", {28'd0, reg_wr_pulse}, 32'd0);

        // BREADY stalled for 5 cycles with a second write waiting
        @(negedge clk);
        bready = 1'b0;
        awaddr = 4'h0; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk);
        #1;
        awaddr = 4'h4; wdata = 32'h66;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bstall_bvalid", {31'd0, bvalid}, 32'd1);
            check("bstall_awready", {31'd0, awready}, 32'd0);
            check("bstall_wready", {31'd0, wready}, 32'd0);
        end
        check("bstall_reg0", reg_out[0], 32'h55);
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bstall_reopen", {31'd0, awready && wready}, 32'd1);
        check("bstall_reg1_held", reg_out[1], 32'hDEAD_BEEF);
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0;
        check("bstall_second_bvalid", {31'd0, bvalid}, 32'd1);
        check("bstall_reg1", reg_out[1], 32'h66);
        @(posedge clk);
        #1;

        // Same-cycle commit and read of register 2
        axi_write(4'h8, 32'h3, 4'hF);
        @(negedge clk);
        awaddr = 4'h8; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'h8; arvalid = 1'b1;
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("same_bvalid", {31'd0, bvalid}, 32'd1);
        check("same_rvalid", {31'd0, rvalid}, 32'd1);
        check("same_rdata_old", rdata, 32'h3);
        @(posedge clk);
        #1;
        axi_read(4'h8, rd, rr);
        check("same_rdata_new", rd, 32'hA5A5_A5A5);

        // RVALID/RDATA held while RREADY low
        rready = 1'b0;
        @(negedge clk);
        araddr = 4'h0; arvalid = 1'b1;
        @(posedge clk);
        #1 arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rhold_rvalid", {31'd0, rvalid}, 32'd1);
            check("rhold_rdata", rdata, 32'h55);
            check("rhold_arready", {31'd0, arready}, 32'd0);
        end
        rready = 1'b1;
        @(posedge clk);
        #1;
        check("rhold_rvalid_clr", {31'd0, rvalid}, 32'd0);
        check("rhold_arready_set", {31'd0, arready}, 32'd1);

        // Reset between AW and W handshakes
        @(negedge clk);
        awaddr = 4'hC; awvalid = 1'b1;
        @(posedge clk);
        #1 awvalid = 1'b0;
        check("abort_aw_taken", {31'd0, awready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("abort_awready", {31'd0, awready}, 32'd0);
        check("abort_bvalid", {31'd0, bvalid}, 32'd0);
        for (int i = 0; i < 4; i++) check("abort_reg", reg_out[i], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wdata = 32'h9999; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk);
        #1 wvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("abort_no_commit", {31'd0, bvalid}, 32'd0);
        end
        check("abort_reg3", reg_out[3], 32'd0);
        @(negedge clk);
        awaddr = 4'h0; awvalid = 1'b1;
        @(posedge clk);
        #1 awvalid = 1'b0;
        @(posedge clk);
        #1;
        axi_write(4'hC, 32'h77, 4'hF);
        axi_read(4'hC, rd, rr);
        check("abort_recover", rd, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/custom_ip_axil_slave.md
CUSTOM_IP_AXIL_SLAVE -- requirements
Module: custom_ip_axil_slave

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32: data bus width; only 32 supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 4: byte address width; selects 4 word registers.
REQ-003 ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 ARESET  in  1  asynchronous, active-high reset.
REQ-005 S00_AXI_AWADDR  in  4, AWPROT in 3, AWVALID in 1, AWREADY out 1  AXI4-Lite write address channel; AWPROT ignored.
REQ-006 S00_AXI_WDATA  in  32, WSTRB in 4, WVALID in 1, WREADY out 1  write data channel.
REQ-007 S00_AXI_BRESP  out  2, BVALID out 1, BREADY in 1  write response channel.
REQ-008 S00_AXI_ARADDR  in  4, ARPROT in 3, ARVALID in 1, ARREADY out 1  read address channel; ARPROT ignored.
REQ-009 S00_AXI_RDATA  out  32, RRESP out 2, RVALID out 1, RREADY in 1  read data channel.
REQ-010 reg_out  out  4x32  current contents of registers 0..3, for fabric use.
REQ-011 reg_wr_pulse  out  4  one-cycle strobe per register, high in the cycle after that register is written.

Function
REQ-012 Register index SHALL be addr[3:2]; addr[1:0] ignored; every address valid; BRESP and RRESP always OKAY (2'b00).
REQ-013 AW and W handshakes SHALL be accepted independently, in either order or in the same cycle; each is buffered in a holding register with a valid flag.
REQ-014 AWREADY SHALL be high iff no address is buffered and BVALID is low; WREADY SHALL be high iff no data is buffered and BVALID is low.
REQ-015 Write FSM states: W_IDLE (none buffered), W_HAVE_A, W_HAVE_D, W_RESP; W_IDLE->W_RESP when both handshakes occur in one cycle; W_HAVE_A/W_HAVE_D->W_RESP on the missing handshake; W_RESP->W_IDLE on BVALID&&BREADY.
REQ-016 On entry to W_RESP, at the same clock edge, the register SHALL be updated byte-wise per WSTRB (WSTRB=0 leaves it unchanged) and BVALID SHALL assert.
REQ-017 BVALID SHALL hold until BREADY; no new AW/W accepted while BVALID high; at most one write outstanding.
REQ-018 ARREADY SHALL be high iff RVALID is low; on AR handshake RDATA is registered from the addressed register and RVALID asserts next cycle (latency 1).
REQ-019 RVALID and RDATA SHALL hold stable until RREADY; RVALID deasserts on the RVALID&&RREADY edge; ARREADY re-asserts the same cycle.
REQ-020 If a write commit and an AR handshake to the same register occur in the same cycle, RDATA SHALL return the pre-write value.
REQ-021 Read and write paths SHALL operate concurrently with no mutual stall.
REQ-022 reg_wr_pulse[i] SHALL be high for exactly one cycle after each commit to register i, including WSTRB=0 commits.

Reset
REQ-023 While ARESET is high: registers 0..3 = 0, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, RDATA=0, BRESP=RRESP=0, reg_wr_pulse=0, FSM=W_IDLE, holding flags cleared.
REQ-024 Ready outputs SHALL assert in the first cycle after ARESET deasserts.
REQ-025 Reset mid-transaction SHALL abort it with no register update; buffered address/data discarded.

Structure
REQ-026 A shared package custom_ip_axil_pkg SHALL hold the write FSM state enum, the AXI response constants (OKAY=2'b00) and the register count constant (4).
REQ-027 One sub-module, custom_ip_axil_regfile (4x32 byte-strobed register array, one write port, one read port), is natural and SHALL be used.

Verification
REQ-028 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read the same addresses -> RDATA 0x1,0x2,0x3,0x4, all RRESP=OKAY.
REQ-029 W handshake 3 cycles before AW (addr 0x4, data 0xDEADBEEF) -> single commit, BVALID one cycle after AW handshake, reg_out[1]=0xDEADBEEF.
REQ-030 Reg 2=0xFFFFFFFF; write 0x12345678 with WSTRB=4'b0101 -> reg 2 reads 0xFF34FF78.
REQ-031 BREADY held low 5 cycles -> BVALID stays high, AWREADY/WREADY stay low, second write accepted only after the B handshake.
REQ-032 Same-cycle commit to 0x8 (0xA5A5A5A5) and AR to 0x8, reg 2 previously 0x3 -> RDATA=0x3; next read -> 0xA5A5A5A5.
REQ-033 ARESET pulsed after AW handshake, before W -> no BVALID, all registers 0, next full write completes normally.
